// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - parallel word handshake into the UART transmitter
interface uart_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - start/data(LSB first)/stop frame serializer with Q/Qbar line pair
module uart_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_serializer_if.slave  tx_if,
  output logic                 tx_out,
  output logic                 tx_out_n,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2 || DATA_W < 1 || DATA_W > 16) begin : g_bad_param
    $error("uart_tx_serializer: parameter out of range");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              out_q;
  logic              out_n_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic              handshake;
  logic              cnt_end;
  logic              bit_last;
  logic [DATA_W-1:0] shift_nxt;
  logic              line_d;

  assign handshake = tx_if.tx_valid && ready_q;
  assign cnt_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BIT_W'(DATA_W - 1));
  assign shift_nxt = shift_q >> 1;

  // Next line level is computed once so the Q and Qbar flops always load complements.
  always_comb begin
    line_d = out_q;
    case (state_q)
      S_IDLE:  if (handshake) line_d = 1'b0;
      S_START: if (cnt_end) line_d = shift_q[0];
      S_DATA:  if (cnt_end) line_d = bit_last ? 1'b1 : shift_nxt[0];
      S_STOP:  if (cnt_end) line_d = 1'b1;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      out_n_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out_q   <= line_d;
      out_n_q <= ~line_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            shift_q <= tx_if.tx_data;
            cnt_q   <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_end) begin
            cnt_q   <= '0;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_end) begin
            cnt_q <= '0;
            if (bit_last) begin
              state_q <= S_STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_nxt;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_end) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_out         = out_q;
  assign tx_out_n       = out_n_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed bench for uart_tx_serializer (CLKS_PER_BIT 4 and 2)
module tb_uart_tx_serializer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  logic a_out, a_out_n, a_busy, a_done;
  logic b_out, b_out_n, b_busy, b_done;

  uart_tx_serializer_if #(.DATA_W(8)) ifa ();
  uart_tx_serializer_if #(.DATA_W(8)) ifb ();

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_if    (ifa),
    .tx_out   (a_out),
    .tx_out_n (a_out_n),
    .tx_busy  (a_busy),
    .tx_done  (a_done)
  );

  uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(2)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_if    (ifb),
    .tx_out   (b_out),
    .tx_out_n (b_out_n),
    .tx_busy  (b_busy),
    .tx_done  (b_done)
  );

  always #5 clk = ~clk;

  // Observed vector order: {tx_out, tx_out_n, tx_busy, tx_ready, tx_done}
  localparam logic [4:0] IDLE_V = 5'b10010;
  localparam logic [4:0] DONE_V = 5'b10011;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] va();
    return {a_out, a_out_n, a_busy, ifa.tx_ready, a_done};
  endfunction

  function automatic logic [4:0] vb();
    return {b_out, b_out_n, b_busy, ifb.tx_ready, b_done};
  endfunction

  // Called at the negedge just after handshake edge 0; returns at the negedge after edge 40.
  task automatic expect_frame(input string tag, input logic [7:0] d,
                              input int pulse_cyc, input logic [7:0] pd);
    logic line;
    int   b;
    for (int c = 0; c < 40; c++) begin
      b    = c / 4;
      line = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : 1'b1;
      check($sformatf("%s_c%0d", tag, c), va(), {line, ~line, 3'b100});
      if (c == pulse_cyc - 1) begin
        ifa.tx_valid = 1'b1;
        ifa.tx_data  = pd;
      end
      if (c == pulse_cyc) ifa.tx_valid = 1'b0;
      @(negedge clk);
    end
    check($sformatf("%s_done", tag), va(), DONE_V);
  endtask

  task automatic start_a(input logic [7:0] d);
    ifa.tx_valid = 1'b1;
    ifa.tx_data  = d;
    @(negedge clk);
  endtask

  initial begin
    logic line;
    int   b;
    ifa.tx_valid = 1'b0;
    ifa.tx_data  = 8'h00;
    ifb.tx_valid = 1'b0;
    ifb.tx_data  = 8'h00;

    // 1: reset with no clock edge
    #1 rst_n = 1'b0;
    #1 check("reset_a", va(), IDLE_V);
    check("reset_b", vb(), IDLE_V);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", va(), IDLE_V);

    // 2: single 0xA5 frame
    start_a(8'hA5);
    ifa.tx_valid = 1'b0;
    expect_frame("a5", 8'hA5, -1, 8'h00);
    @(negedge clk);
    check("a5_done_one_cycle", va(), IDLE_V);
    repeat (2) @(negedge clk);

    // 4: request while busy is ignored
    start_a(8'hA5);
    ifa.tx_valid = 1'b0;
    expect_frame("busy_ign", 8'hA5, 10, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("busy_ign_idle%0d", i), va(), IDLE_V);
    end

    // 3: back-to-back with tx_valid held; data change mid-frame has no effect
    start_a(8'h00);
    ifa.tx_data = 8'hFF;
    expect_frame("b2b_first", 8'h00, -1, 8'h00);
    @(negedge clk);
    ifa.tx_valid = 1'b0;
    expect_frame("b2b_second", 8'hFF, -1, 8'h00);
    @(negedge clk);
    check("b2b_no_third", va(), IDLE_V);

    // 5: reset mid-frame
    start_a(8'hA5);
    ifa.tx_valid = 1'b0;
    repeat (18) @(negedge clk);
    check("mid_frame_c18", va(), 5'b01100);
    #1 rst_n = 1'b0;
    #1 check("reset_abort", va(), IDLE_V);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", i), va(), IDLE_V);
    end
    start_a(8'hA5);
    ifa.tx_valid = 1'b0;
    expect_frame("post_reset", 8'hA5, -1, 8'h00);

    // 6: CLKS_PER_BIT=2, 0x80
    ifb.tx_valid = 1'b1;
    ifb.tx_data  = 8'h80;
    @(negedge clk);
    ifb.tx_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      b    = c / 2;
      line = (b == 0) ? 1'b0 : (b == 8) ? 1'b1 : (b == 9) ? 1'b1 : 1'b0;
      check($sformatf("cpb2_c%0d", c), vb(), {line, ~line, 3'b100});
      @(negedge clk);
    end
    check("cpb2_done", vb(), DONE_V);
    @(negedge clk);
    check("cpb2_idle", vb(), IDLE_V);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
